// File: rtl/data_ram_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes,
// fault codes and the clear/ready sequencer states.
package data_ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane steering for the data memory: turns a right-justified
// store value into byte enables plus replicated lane data, and pulls a
// byte/half/word out of a read word with sign or zero extension.
module ram_lane_align
  import data_ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] data_write,
  input  logic [31:0] rd_word,
  input  logic        unsigned_ld,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the source across lanes and enable only the addressed ones
  always_comb begin
    byte_en = 4'b0000;
    wr_data = 32'h0;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{data_write[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{data_write[15:0]}};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wr_data = data_write;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  // Load side: select the addressed byte/half (little-endian) and extend it
  always_comb begin
    ld_byte = 8'h0;
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'h0;
    case (lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    case (size)
      SZ_BYTE: ld_data = unsigned_ld ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = unsigned_ld ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Word-organised data memory for the MIPS MEM stage. Byte/half/word stores
// and loads, registered read with a valid strobe, fault flagging, and an
// optional post-reset sequencer that zeroes one word per cycle.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_write,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  output logic [31:0]           data_out,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  error,
  output logic [1:0]            error_code
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [31:0]      mem [DEPTH];
  state_t           state, state_next;
  logic [IDX_W-1:0] clr_idx;
  logic             clear_we;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [1:0]       fault_code;
  logic             fault;
  logic             accept_wr;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  logic [31:0]      ld_data;

  assign word_idx  = address[IDX_W+1:2];
  assign rd_word   = mem[word_idx];
  assign fault     = (fault_code != ERR_NONE);
  assign accept_wr = (state == READY) && write_en && !fault;

  ram_lane_align u_align (
    .size        (size),
    .lane        (address[1:0]),
    .data_write  (data_write),
    .rd_word     (rd_word),
    .unsigned_ld (unsigned_ld),
    .byte_en     (byte_en),
    .wr_data     (wr_data),
    .ld_data     (ld_data)
  );

  // Classify the request; illegal size outranks misalignment, which outranks range
  always_comb begin
    fault_code = ERR_NONE;
    if (size == SZ_ILL) begin
      fault_code = ERR_SIZE;
    end else if ((size == SZ_HALF && address[0]) ||
                 (size == SZ_WORD && address[1:0] != 2'b00)) begin
      fault_code = ERR_MISALIGN;
    end else if ({1'b0, address} >= BYTE_LIMIT) begin
      fault_code = ERR_RANGE;
    end
  end

  // Sequencer next state: sweep every word while clearing, then sit in READY
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    clear_we   = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Sequencer state and clear index; reset restarts the sweep from word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (clear_we) begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // Memory array: zeroed by the sequencer or updated lane-by-lane by a clean store
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_we) begin
        mem[clr_idx] <= 32'h0;
      end else if (accept_wr) begin
        for (int l = 0; l < 4; l++) begin
          if (byte_en[l]) begin
            mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
          end
        end
      end
    end
  end

  // Output registers: one-cycle read/error strobes, held load data and fault code
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= 32'h0;
      rd_valid   <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
    end else begin
      rd_valid <= 1'b0;
      error    <= 1'b0;
      if (state == READY) begin
        if (read_en) begin
          rd_valid <= 1'b1;
          data_out <= fault ? 32'h0 : ld_data;
        end
        if ((read_en || write_en) && fault) begin
          error      <= 1'b1;
          error_code <= fault_code;
        end
      end
    end
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Parameterised word-organised data memory for the MIPS datapath MEM stage.
- Supports byte, halfword and word loads/stores with sign or zero extension.
- Registered read with valid strobe; misaligned, out-of-range and illegal-size accesses are flagged.
- After reset, a clear sequencer zeroes every word one per cycle and signals busy while doing so.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- ADDR_WIDTH, 32, byte-address width on the port.
- CLEAR_ON_RESET, 1; 1 runs the zeroing sequencer after reset, 0 skips it and goes straight to READY.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address of the access.
- data_write  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- write_en  in  1  store request this cycle.
- read_en  in  1  load request this cycle.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  in  1  1 zero-extends byte/half loads, 0 sign-extends them.
- data_out  out  32  registered load result.
- rd_valid  out  1  one-cycle pulse: data_out is valid this cycle.
- busy  out  1  high while clearing; all requests are ignored.
- error  out  1  one-cycle pulse, one cycle after a faulting request.
- error_code  out  2  01 misaligned, 10 out of range, 11 illegal size; held until the next error.

Behaviour:
- Reset values (synchronous, takes priority over everything): data_out=0, rd_valid=0, error=0, error_code=00, clear index=0. State=CLEAR (busy=1) if CLEAR_ON_RESET=1, else READY (busy=0). Memory contents are not touched by reset itself.
- FSM state CLEAR: each cycle mem[idx] is set to 0 and idx increments. When idx==DEPTH-1, that word is written and the next state is READY. CLEAR lasts exactly DEPTH cycles; busy is high throughout.
- FSM state READY: busy=0 and requests are accepted. READY is exited only by reset.
- Reset asserted mid-clear restarts the clear at idx=0.
- Requests while busy: no memory write, rd_valid=0, error=0.
- Word index = address[log2(DEPTH)+1:2]; byte lane = address[1:0], little-endian.
- Fault checks, in priority order:
  - size==11 gives code 11.
  - half with address[0]=1, or word with address[1:0]!=0, gives code 01.
  - address >= DEPTH*4 gives code 10.
  - A faulting access never writes memory. A faulting read still pulses rd_valid with data_out=0.
- Store (write_en=1, no fault): at the edge, only the addressed byte lanes update.
  - byte: lane address[1:0] takes data_write[7:0].
  - half: lanes {address[1],0} and {address[1],1} take data_write[15:0].
  - word: all four lanes update.
- Load (read_en=1, no fault): latency 1. data_out is set to the extracted, extended value and rd_valid=1 on the next cycle.
- data_out holds its last value when no read is in progress; it never goes X.
- write_en and read_en together: both are performed; the read returns the pre-write contents (read-before-write).
- With no request, rd_valid=0 and error=0.

Decomposition:
- Package data_ram_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - error codes ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_SIZE;
  - FSM state encodings CLEAR, READY.
- One combinational sub-module, ram_lane_align, contains:
  - store byte-enable and lane-shift generation;
  - load byte/half extraction and sign/zero extension.
- data_ram holds the array, FSM, clear counter and output registers.

Test Plan:
- Clear: reset 1 cycle, DEPTH=16 -> busy high exactly 16 cycles. A write to 0x0 issued during that time is ignored; reading 0x0 afterwards returns 0x00000000.
- Byte/half stores: sw 0x0=0x11223344, then sb 0x1 with 0xAB, then sh 0x2 with 0xBEEF -> lw 0x0 returns 0xBEEFAB44, rd_valid exactly 1 cycle after read_en.
- Extension: mem[1]=0x000080F0; lb 0x4 returns 0xFFFFFFF0; lbu 0x4 returns 0x000000F0; lh 0x4 returns 0xFFFF80F0; lhu 0x4 returns 0x000080F0.
- Faults: sw 0x2 -> error pulse, code 01, mem unchanged. lw 0x400 with DEPTH=256 -> code 10, data_out=0, rd_valid=1. size=11 -> code 11.
- Simultaneous: mem[3]=0x5; read and write 0x9 to 0xC together -> read returns 0x5; next lw returns 0x9.
- Mid-clear reset: reset, wait 5 cycles, reset again -> busy stays high DEPTH cycles from the second reset, and every word reads 0.
